// File: rtl/sort_sequencer_if.sv
// sort_sequencer_if: handshake bundle for the 8-element sort sequencer.
// The master side offers input elements and consumes sorted output;
// the slave side is the sequencer itself.
interface sort_sequencer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sort_sequencer.sv
// sort_sequencer: collects 8 unsigned W-bit elements, sorts them with a
// 6-stage bitonic network (one stage per clock, four compare-exchange
// units in parallel) and streams them out in ascending order.
// Optional macro SORT_SEQUENCER_DESC_EN adds a 'desc' input, sampled on
// the 8th accept, which streams the sorted set out largest-first.
module sort_sequencer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
`ifdef SORT_SEQUENCER_DESC_EN
  input  logic desc,
`endif
  sort_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [2:0]   stage_q, stage_d;
  logic [W-1:0] r_q [8];
  logic [W-1:0] r_d [8];
  logic         desc_q, desc_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [W-1:0] out_data_q, out_data_d;

  // Compare-exchange wiring for the current stage: unit k compares
  // ca[k] against cb[k]; cup[k]=1 puts the minimum in ca[k].
  logic [2:0]   ca [4];
  logic [2:0]   cb [4];
  logic [3:0]   cup;
  logic [2:0]   sel;

  // Bitonic network topology, selected by the stage counter.
  always_comb begin
    ca  = '{3'd0, 3'd2, 3'd4, 3'd6};
    cb  = '{3'd1, 3'd3, 3'd5, 3'd7};
    cup = 4'b1111;
    case (stage_q)
      3'd0: begin
        ca  = '{3'd0, 3'd2, 3'd4, 3'd6};
        cb  = '{3'd1, 3'd3, 3'd5, 3'd7};
        cup = 4'b0101;
      end
      3'd1: begin
        ca  = '{3'd0, 3'd1, 3'd4, 3'd5};
        cb  = '{3'd2, 3'd3, 3'd6, 3'd7};
        cup = 4'b0011;
      end
      3'd2: begin
        ca  = '{3'd0, 3'd2, 3'd4, 3'd6};
        cb  = '{3'd1, 3'd3, 3'd5, 3'd7};
        cup = 4'b0011;
      end
      3'd3: begin
        ca  = '{3'd0, 3'd1, 3'd2, 3'd3};
        cb  = '{3'd4, 3'd5, 3'd6, 3'd7};
        cup = 4'b1111;
      end
      3'd4: begin
        ca  = '{3'd0, 3'd1, 3'd4, 3'd5};
        cb  = '{3'd2, 3'd3, 3'd6, 3'd7};
        cup = 4'b1111;
      end
      default: begin
        ca  = '{3'd0, 3'd2, 3'd4, 3'd6};
        cb  = '{3'd1, 3'd3, 3'd5, 3'd7};
        cup = 4'b1111;
      end
    endcase
  end

  // Next-state, datapath and next-output logic of the LOAD/SORT/OUT FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    r_d     = r_q;
    desc_d  = desc_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          r_d[idx_q] = bus.in_data;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            stage_d = 3'd0;
            state_d = ST_SORT;
`ifdef SORT_SEQUENCER_DESC_EN
            desc_d  = desc;
`else
            desc_d  = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_SORT: begin
        for (int k = 0; k < 4; k++) begin
          // Unit index pairs are disjoint within a stage, so reading r_q
          // and writing r_d never collide between units.
          if (cup[k] ? (r_q[ca[k]] > r_q[cb[k]]) : (r_q[ca[k]] < r_q[cb[k]])) begin
            r_d[ca[k]] = r_q[cb[k]];
            r_d[cb[k]] = r_q[ca[k]];
          end else begin
            r_d[ca[k]] = r_q[ca[k]];
            r_d[cb[k]] = r_q[cb[k]];
          end
        end
        if (stage_q == 3'd5) begin
          stage_d = 3'd0;
          state_d = ST_OUT;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = 3'd0;
        stage_d = 3'd0;
      end
    endcase

    // Outputs are computed from next-state values so they are registered
    // yet aligned with the state they describe.
    sel         = idx_d ^ {3{desc_d}};
    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d == ST_SORT);
    out_data_d  = (state_d == ST_OUT) ? r_d[sel] : {W{1'b0}};
  end

  // State, register file and output flops; reset discards any set in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= 3'd0;
      stage_q     <= 3'd0;
      desc_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {W{1'b0}};
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      desc_q      <= desc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      r_q         <= r_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: scoreboard bench for sort_sequencer. Sets of 8 values
// are queued for the input driver while their sorted order (computed with a
// plain sort) is queued as expectation; a monitor pops and compares on every
// output transfer.
module tb_sort_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sort_sequencer_if #(.W(W)) bus ();
`ifdef SORT_SEQUENCER_DESC_EN
  logic desc = 1'b0;
`endif

  sort_sequencer #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SORT_SEQUENCER_DESC_EN
    .desc  (desc),
`endif
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int inq[$];
  int exp_q[$];
  int accepts = 0;
  bit hold = 1'b0;
  bit rnd_rdy = 1'b0;
  int busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Queue one set for the driver and its sorted order for the monitor.
  task automatic push_set(input int v[8], input bit dsc);
    int s[8];
    int t;
    s = v;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    for (int i = 0; i < 8; i++) inq.push_back(v[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(dsc ? s[7-i] : s[i]);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || inq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    inq.delete();
    exp_q.delete();
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);
  endtask

  // Input driver: present the queue head, pop once the DUT took it.
  initial begin
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready && !reset;
      @(posedge clk);
      #1;
      if (acc && inq.size() > 0) begin
        void'(inq.pop_front());
        accepts++;
      end
      if (inq.size() > 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = inq[0][W-1:0];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  end

  // Output-ready driver: always ready, random, or held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold) bus.out_ready = 1'b0;
      else if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops, handshake exclusivity, SORT duration.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (bus.in_ready && bus.out_valid) check("ready_valid_excl", 1, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", bus.out_data, 32'hFFFF_FFFF);
        else check("out_data", bus.out_data, exp_q.pop_front());
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_cycles", busy_run, 6);
        check("valid_after_sort", bus.out_valid, 1);
        busy_run = 0;
      end
    end
  end

  initial begin
    int a[8];
    int n;
    int start;
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);

    // Basic permutation.
    a = '{8, 3, 7, 1, 6, 2, 5, 4};
    push_set(a, 1'b0);
    drain(200);

    // Duplicates and extremes.
    a = '{200, 200, 0, 255, 17, 17, 0, 128};
    push_set(a, 1'b0);
    drain(200);

    // Consumer stall: first element must stay put.
    hold = 1'b1;
    a = '{9, 44, 3, 250, 3, 61, 128, 7};
    push_set(a, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_data", bus.out_data, exp_q[0]);
      check("stall_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    hold = 1'b0;
    drain(200);

    // Reset after the 4th accept, then a clean set.
    a = '{90, 80, 70, 60, 50, 40, 30, 20};
    push_set(a, 1'b0);
    start = accepts;
    n = 0;
    while (accepts - start < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("four_accepts", (accepts - start >= 4), 1);
    do_reset();
    a = '{8, 7, 6, 5, 4, 3, 2, 1};
    push_set(a, 1'b0);
    drain(200);

    // Reset in the middle of SORT.
    a = '{11, 22, 33, 44, 55, 66, 77, 88};
    push_set(a, 1'b0);
    n = 0;
    while (!bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", bus.busy, 1);
    do_reset();

    // Back-to-back sets: in_valid stays high through SORT and OUT.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) a[i] = $urandom_range(0, 255);
      push_set(a, 1'b0);
    end
    drain(400);

    // Randomized sets with a random consumer.
    rnd_rdy = 1'b1;
    for (int it = 0; it < 12; it++) begin
      for (int s = 0; s < 1 + (it % 2); s++) begin
        for (int i = 0; i < 8; i++)
          a[i] = (it % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        push_set(a, 1'b0);
      end
      drain(600);
    end
    rnd_rdy = 1'b0;

`ifdef SORT_SEQUENCER_DESC_EN
    desc = 1'b1;
    a = '{1, 2, 3, 4, 5, 6, 7, 8};
    push_set(a, 1'b1);
    drain(200);
    desc = 1'b0;
    a = '{1, 2, 3, 4, 5, 6, 7, 8};
    push_set(a, 1'b0);
    drain(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, meaning element width in bits (unsigned compare).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  input element offered.
REQ-005 SHALL have port in_data  input  W  input element.
REQ-006 SHALL have port in_ready  output  1  block accepts an input element.
REQ-007 SHALL have port out_valid  output  1  sorted element presented.
REQ-008 SHALL have port out_data  output  W  sorted element.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the output element.
REQ-010 SHALL have port busy  output  1  high while in SORT state.
REQ-011 SHALL use one clock (clk) and an asynchronous active-high reset (reset); no other clocks or resets.

Function
REQ-012 SHALL hold an 8-entry register file R[0..7] of W bits, a 3-bit element index and a 3-bit stage counter.
REQ-013 SHALL implement FSM states LOAD, SORT, OUT; LOAD is the reset state.
REQ-014 LOAD: in_ready=1; on a rising edge with in_valid&in_ready, R[index]<=in_data and index increments; the 8th accept (index 7) SHALL clear index and stage and enter SORT.
REQ-015 SORT: in_ready=0, out_valid=0, busy=1; each cycle SHALL apply one bitonic stage with four parallel compare-exchange units, then increment stage; after stage 5 SHALL enter OUT.
REQ-016 Compare-exchange (a,b) "up" SHALL place min in a, max in b; "down" SHALL place max in a, min in b; equal values SHALL be left unchanged.
REQ-017 Stage 0: (0,1)up (2,3)down (4,5)up (6,7)down.
REQ-018 Stage 1: (0,2)up (1,3)up (4,6)down (5,7)down.
REQ-019 Stage 2: (0,1)up (2,3)up (4,5)down (6,7)down.
REQ-020 Stage 3: (0,4) (1,5) (2,6) (3,7), all up.
REQ-021 Stage 4: (0,2) (1,3) (4,6) (5,7), all up.
REQ-022 Stage 5: (0,1) (2,3) (4,5) (6,7), all up; R is then ascending.
REQ-023 OUT: out_valid=1, out_data=R[index] (registered path, stable while out_ready=0); each out_valid&out_ready edge increments index; the 8th transfer SHALL clear index and return to LOAD.
REQ-024 Latency: 8th input accept at edge E0; stages apply at edges E1..E6; out_valid SHALL be high in the cycle following E6 (exactly 6 cycles of busy).
REQ-025 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside OUT.
REQ-026 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-027 reset SHALL asynchronously force state=LOAD, index=0, stage=0, R[*]=0.
REQ-028 During reset: in_ready=0, out_valid=0, busy=0, out_data=0; in_ready SHALL rise the first cycle after reset deasserts.
REQ-029 Reset mid-LOAD, mid-SORT or mid-OUT SHALL discard the current set; no partial output follows.

Configuration
REQ-030 Macro SORT_SEQUENCER_DESC_EN: when defined, SHALL add input port desc (1 bit), sampled at the E0 edge into a mode flag; flag=1 SHALL present OUT elements in order R[7]..R[0] (descending).
REQ-031 Without SORT_SEQUENCER_DESC_EN: no desc port; output order SHALL always be ascending R[0]..R[7].

Verification
REQ-032 Load 8,3,7,1,6,2,5,4 with out_ready=1 -> out_data 1,2,3,4,5,6,7,8 on consecutive cycles; busy high exactly 6 cycles.
REQ-033 Load 200,200,0,255,17,17,0,128 -> output 0,0,17,17,128,200,200,255 (duplicates, extremes).
REQ-034 Hold out_ready=0 for 5 cycles after out_valid rises -> out_data stays at smallest value, index unchanged; in_ready stays 0.
REQ-035 Assert reset after 4th input accept, then load 1..8 reversed -> outputs 1..8 only; no earlier data appears.
REQ-036 With SORT_SEQUENCER_DESC_EN and desc=1 at E0, load 1..8 -> output 8,7,...,1; next set with desc=0 -> ascending.
REQ-037 Drive in_valid=1 continuously during SORT and OUT -> no writes to R; second set loads only after the 8th output transfer.
